// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - FSM state encodings (IDLE..HOLD)
//   - default requester count
//   - onehot(): index to one-hot requester mask (up to 8 requesters)
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] WSTART = 3'd2;
  localparam logic [2:0] WDONE  = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  localparam int DEFAULT_NREQ = 4;

  // Callers truncate the result to their own requester count.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/xmit_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req   - per-requester valid bits
//   ptr   - index where the search starts (wraps modulo NREQ)
//   valid - at least one requester is asking
//   idx   - first requesting index at or after ptr
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  // Walk the offsets from farthest to nearest so the candidate closest to
  // ptr is written last and wins. The modulo keeps the wrap correct when
  // NREQ is not a power of two.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/xmit_arb.sv
// xmit_arb: round-robin arbiter sharing one UART transmitter between NREQ
// byte requesters. Once a requester is granted, the transmitter stays locked
// to it until a byte flagged 'last' has gone out (or the owner stalls for
// HOLDTIMEOUT clocks), so messages never interleave.
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   req/data/last - per-requester byte valid, byte (8 bits each), end flag
//   ack      - one-clock pulse, byte from requester i has been taken
//   char     - registered byte to the transmitter
//   sendchar - one-clock start pulse to the transmitter
//   busy     - transmitter busy
//   owner    - one-hot lock holder (0 when unlocked)
//   locked   - a message lock is held
module xmit_arb
  import uart_pkg::*;
#(
  parameter int NREQ        = DEFAULT_NREQ,
  parameter int HOLDTIMEOUT = 1_200_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        char,
  output logic              sendchar,
  input  logic              busy,
  output logic [NREQ-1:0]   owner,
  output logic              locked
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLDTIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDTIMEOUT - 1);

  logic [2:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          lastq;
  logic [HW-1:0] hold_cnt;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] src;
  logic [IW-1:0] ptr_next;
  logic [7:0]    sel_byte;
  logic          sel_last;
  logic          grant;
  logic          release_lock;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // While holding a message only the owner may supply the next byte, so
  // the byte source is the current owner in HOLD and the fresh pick in IDLE.
  // Release happens either after the final byte drains or when the owner
  // has been silent long enough in HOLD.
  always_comb begin
    src          = (state == HOLD) ? idx : pick_idx;
    sel_byte     = data[8*int'(src) +: 8];
    sel_last     = last[src];
    ptr_next     = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    grant        = ((state == IDLE) && pick_valid) ||
                   ((state == HOLD) && req[idx]);
    release_lock = ((state == WDONE) && !busy && lastq) ||
                   ((state == HOLD) && !req[idx] && (hold_cnt == HOLD_LAST));
  end

  // Main FSM. ack and sendchar are registered together on the grant edge so
  // both are high only during the LOAD clock. The hold counter stops at
  // HOLD_LAST because reaching it releases the lock, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      lastq    <= 1'b0;
      hold_cnt <= '0;
      ack      <= '0;
      char     <= 8'h00;
      sendchar <= 1'b0;
      owner    <= '0;
      locked   <= 1'b0;
    end else begin
      ack      <= '0;
      sendchar <= 1'b0;
      if (grant) begin
        idx      <= src;
        owner    <= NREQ'(onehot(3'(src)));
        ack      <= NREQ'(onehot(3'(src)));
        locked   <= 1'b1;
        char     <= sel_byte;
        lastq    <= sel_last;
        sendchar <= 1'b1;
        state    <= LOAD;
      end else if (release_lock) begin
        owner  <= '0;
        locked <= 1'b0;
        ptr    <= ptr_next;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE:   state <= IDLE;
          LOAD:   state <= WSTART;
          WSTART: if (busy) state <= WDONE;
          WDONE: begin
            if (!busy) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
          HOLD:   hold_cnt <= hold_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
